// File: rtl/saturn_alu_sequencer_pkg.sv
// saturn_alu_sequencer_pkg: state encoding shared by the ALU sequencer files
package saturn_alu_sequencer_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_CALC, ST_SAVE, ST_DONE} state_t;
endpackage

// File: rtl/saturn_alu_sequencer_nibble_iter.sv
// saturn_nibble_iter: mod-16 nibble counter with load, step and last-nibble compare
module saturn_nibble_iter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [3:0] start,
  input  logic [3:0] last,
  output logic [3:0] nibble,
  output logic       at_last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) nibble <= '0;
    else if (load) nibble <= start;
    else if (step) nibble <= nibble + 4'd1;
  assign at_last = nibble == last;
endmodule

// File: rtl/saturn_alu_sequencer.sv
// saturn_alu_sequencer: walks a nibble field issuing ALU prep/calc/save phases per nibble
module saturn_alu_sequencer
  import saturn_alu_sequencer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_op_valid,
  input  logic [4:0] i_alu_op,
  input  logic [3:0] i_field_start,
  input  logic [3:0] i_field_last,
  input  logic       i_stall,
  output logic       o_op_ready,
  output logic       o_en_alu_prep,
  output logic       o_en_alu_calc,
  output logic       o_en_alu_save,
  output logic [4:0] o_alu_op,
  output logic [3:0] o_field_start,
  output logic [3:0] o_field_last,
  output logic [3:0] o_nibble,
  output logic       o_busy,
  output logic       o_done
);
  state_t state, state_nx;
  logic accept, at_last;
  assign o_busy        = state != ST_IDLE;
  assign o_op_ready    = state == ST_IDLE && !i_stall;
  assign accept        = o_op_ready && i_op_valid;
  assign o_en_alu_prep = state == ST_PREP && !i_stall;
  assign o_en_alu_calc = state == ST_CALC && !i_stall;
  assign o_en_alu_save = state == ST_SAVE && !i_stall;
  // done is not gated by stall so the decoder sees it for the whole stalled DONE cycle
  assign o_done        = state == ST_DONE;
  always_comb begin
    state_nx = state;
    if (!i_stall)
      unique case (state)
        ST_IDLE: state_nx = accept ? ST_PREP : ST_IDLE;
        ST_PREP: state_nx = ST_CALC;
        ST_CALC: state_nx = ST_SAVE;
        ST_SAVE: state_nx = at_last ? ST_DONE : ST_PREP;
        default: state_nx = ST_IDLE;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      o_alu_op      <= '0;
      o_field_start <= '0;
      o_field_last  <= '0;
    end else if (accept) begin
      o_alu_op      <= i_alu_op;
      o_field_start <= i_field_start;
      o_field_last  <= i_field_last;
    end
  saturn_nibble_iter u_iter (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .load   (accept),
    .step   (o_en_alu_save && !at_last),
    .start  (i_field_start),
    .last   (o_field_last),
    .nibble (o_nibble),
    .at_last(at_last)
  );
endmodule

// File: tb/tb_saturn_alu_sequencer.sv
// tb_saturn_alu_sequencer: scoreboard bench; issued ops queue expected phase/done events
module tb_saturn_alu_sequencer;
  import saturn_alu_sequencer_pkg::*;
  logic clk = 0, rst_n = 0, op_valid = 0, stall = 0;
  logic [4:0] op_in = 0;
  logic [3:0] fs_in = 0, fl_in = 0;
  logic ready, prep, calc, save, busy, done;
  logic [4:0] alu_op;
  logic [3:0] fstart, flast, nibble;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int cyc; int kind; logic [3:0] nib; logic [4:0] op;} ev_t;
  ev_t sb[$];

  saturn_alu_sequencer dut (
    .i_clk(clk), .i_reset(rst_n), .i_op_valid(op_valid), .i_alu_op(op_in),
    .i_field_start(fs_in), .i_field_last(fl_in), .i_stall(stall),
    .o_op_ready(ready), .o_en_alu_prep(prep), .o_en_alu_calc(calc), .o_en_alu_save(save),
    .o_alu_op(alu_op), .o_field_start(fstart), .o_field_last(flast), .o_nibble(nibble),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", nm, a, e);
    end
  endtask

  // expected phase j of N*3 phases, then done; phases from index p onward shift by d stall cycles
  task automatic push(input int acc, input logic [4:0] op, input logic [3:0] s, input logic [3:0] l,
                      input int p, input int d, input int lim);
    logic [3:0] diff;
    int n;
    diff = l - s;
    n = int'(diff) + 1;
    for (int j = 0; j <= 3 * n && j < lim; j++) begin
      ev_t e;
      e.cyc = acc + 1 + j + (j >= p ? d : 0);
      e.kind = (j == 3 * n) ? 3 : j % 3;
      e.nib = (j == 3 * n) ? l : 4'(int'(s) + j / 3);
      e.op = op;
      sb.push_back(e);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] s, input logic [3:0] l,
                       input int p, input int d, input int lim, output int acc);
    int t = 0;
    op_valid = 1; op_in = op; fs_in = s; fl_in = l;
    @(negedge clk);
    while (!ready && t < 300) begin @(negedge clk); t++; end
    if (!ready) chk("accept_timeout", int'(ready), 1);
    acc = cyc;
    push(acc, op, s, l, p, d, lim);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && t < 300) begin @(negedge clk); t++; end
    if (busy || sb.size() != 0) chk("idle_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) if (rst_n) begin
    if (stall) chk("stall_quiet", int'({prep, calc, save, ready}), 0);
    if (int'(prep) + int'(calc) + int'(save) > 1) chk("one_hot", int'({prep, calc, save}), 0);
    if (prep || calc || save || (done && !stall)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d pcsd=%b%b%b%b required none", cyc, prep, calc, save, done);
      end else begin
        ev_t e;
        int k;
        e = sb.pop_front();
        k = prep ? 0 : calc ? 1 : save ? 2 : 3;
        if (cyc != e.cyc || k != e.kind || nibble !== e.nib || alu_op !== e.op) begin
          errors++;
          $display("FAIL event got cyc=%0d kind=%0d nib=%h op=%0d required cyc=%0d kind=%0d nib=%h op=%0d",
                   cyc, k, nibble, alu_op, e.cyc, e.kind, e.nib, e.op);
        end
      end
    end
  end

  initial begin
    int k, k2;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_en", int'({prep, calc, save}), 0);
    chk("rst_fields", int'({alu_op, fstart, flast, nibble}), 0);
    rst_n = 1; #1;
    chk("rel_ready", int'(ready), 1);
    @(posedge clk); #1;
    issue(5'd5, 4'd3, 4'd3, 99, 0, 99, k); op_valid = 0; wait_idle();
    issue(5'd9, 4'd0, 4'd15, 99, 0, 99, k); op_valid = 0; wait_idle();
    issue(5'd2, 4'd14, 4'd1, 99, 0, 99, k); op_valid = 0; wait_idle();
    issue(5'd4, 4'd0, 4'd2, 4, 2, 99, k); op_valid = 0;
    repeat (4) @(posedge clk); #1;
    stall = 1;
    repeat (2) @(posedge clk); #1;
    stall = 0;
    wait_idle();
    issue(5'd3, 4'd2, 4'd3, 99, 0, 99, k);
    issue(5'd7, 4'd5, 4'd5, 99, 0, 99, k2); op_valid = 0;
    chk("b2b_accept_cycle", k2 - k, 8);
    wait_idle();
    issue(5'd6, 4'd0, 4'd3, 99, 0, 8, k); op_valid = 0;
    repeat (8) @(posedge clk); #1;
    rst_n = 0; #1;
    chk("mid_rst_en", int'({prep, calc, save}), 0);
    chk("mid_rst_busy_done", int'({busy, done}), 0);
    chk("mid_rst_fields", int'({alu_op, fstart, flast, nibble}), 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1; #1;
    chk("mid_rst_ready", int'(ready), 1);
    issue(5'd1, 4'd7, 4'd8, 99, 0, 99, k); op_valid = 0; wait_idle();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
